// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is off, static-high, or a PWM waveform with a shared 8-bit duty.
// The duty is shadowed and swapped only at period boundaries, so every period carries a single duty.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_cnt;
    logic [7:0]       r_duty_act;
    logic             r_wrap;
    logic             r_period_start;
    logic [15:0]      r_out;

    logic             w_tick;
    logic             w_boundary;
    logic             w_pwm_level;
    logic [15:0]      w_en_out;
    logic [15:0]      w_en_pwm;
    logic [15:0]      w_out_next;

    // With CLK_DIV=1 the prescaler is pinned at 0 and PRE_MAX is 0, so tick is always 1.
    assign w_tick      = (r_pre == PRE_MAX);
    assign w_boundary  = w_tick && (r_cnt == 8'hFF);
    assign w_pwm_level = (r_duty_act == 8'hFF) || (r_cnt < r_duty_act);
    assign w_en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_out_next  = w_en_out & (~w_en_pwm | {16{w_pwm_level}});

    // r_wrap marks the first cycle with cnt==0; period_start is delayed once more to line up with out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre          <= '0;
            r_cnt          <= 8'd0;
            r_duty_act     <= 8'd0;
            r_wrap         <= 1'b0;
            r_period_start <= 1'b0;
            r_out          <= 16'h0000;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_boundary) begin
                r_duty_act <= pwm_duty_cycle;
            end
            r_wrap         <= w_boundary;
            r_period_start <= r_wrap;
            r_out          <= w_out_next;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
endmodule
